fetch_queue: RTL and testbench

// - Instruction fetch queue directly downstream of the fetch engine, upstream of decode.
// - Buffers fetched instructions with their pc and branch-prediction metadata (taken, target).
// - Decouples fetch from decode stalls; on a pipeline redirect, flush discards all entries.

---
 rtl/fetch_queue.sv | 123 ++++++++++++
 tb/tb_fetch_queue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch engine and decode, with prediction metadata.
// Optional empty-queue same-cycle bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int WIDTH   = 64,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clkEn,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_pc,
    input  logic [INSTR_W-1:0]       in_instr,
    input  logic                     in_pred_taken,
    input  logic [WIDTH-1:0]         in_pred_target,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_pc,
    output logic [INSTR_W-1:0]       out_instr,
    output logic                     out_pred_taken,
    output logic [WIDTH-1:0]         out_pred_target,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [AW:0]        rd_ptr;
    logic [AW:0]        wr_ptr;
    logic [WIDTH-1:0]   pc_mem     [DEPTH];
    logic [INSTR_W-1:0] instr_mem  [DEPTH];
    logic               taken_mem  [DEPTH];
    logic [WIDTH-1:0]   target_mem [DEPTH];

    logic active;
    logic full;
    logic empty;
    logic q_valid;
    logic take;
    logic push;
    logic pop;

    assign active  = clkEn & rst;
    assign empty   = (rd_ptr == wr_ptr);
    assign full    = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) &&
                     (rd_ptr[AW] != wr_ptr[AW]);
    assign in_ready = active & ~full;
    assign q_valid  = active & ~empty;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;

    assign bypass = active & empty & in_valid & ~flush;
    assign take   = bypass & out_ready;

    always_comb begin
        out_valid       = q_valid | bypass;
        out_pc          = pc_mem[rd_ptr[AW-1:0]];
        out_instr       = instr_mem[rd_ptr[AW-1:0]];
        out_pred_taken  = taken_mem[rd_ptr[AW-1:0]];
        out_pred_target = target_mem[rd_ptr[AW-1:0]];
        if (bypass) begin
            out_pc          = in_pc;
            out_instr       = in_instr;
            out_pred_taken  = in_pred_taken;
            out_pred_target = in_pred_target;
        end
    end
`else
    assign take            = 1'b0;
    assign out_valid       = q_valid;
    assign out_pc          = pc_mem[rd_ptr[AW-1:0]];
    assign out_instr       = instr_mem[rd_ptr[AW-1:0]];
    assign out_pred_taken  = taken_mem[rd_ptr[AW-1:0]];
    assign out_pred_target = target_mem[rd_ptr[AW-1:0]];
`endif

    // A bypassed-and-consumed entry never touches storage.
    assign push = in_valid & in_ready & ~flush & ~take;
    assign pop  = q_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clkEn) begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + ONE;
                if (pop)
                    rd_ptr <= rd_ptr + ONE;
                if (push && !pop)
                    count <= count + ONE;
                else if (pop && !push)
                    count <= count - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]     <= '0;
                instr_mem[i]  <= '0;
                taken_mem[i]  <= 1'b0;
                target_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr[AW-1:0]]     <= in_pc;
            instr_mem[wr_ptr[AW-1:0]]  <= in_instr;
            taken_mem[wr_ptr[AW-1:0]]  <= in_pred_taken;
            target_mem[wr_ptr[AW-1:0]] <= in_pred_target;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based model.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        clkEn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic        in_pred_taken;
    logic [63:0] in_pred_target;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_pred_taken;
    logic [63:0] out_pred_target;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        tk;
        logic [63:0] tgt;
    } ent_t;

    ent_t q[$];

    fetch_queue dut (
        .clk(clk), .rst(rst), .clkEn(clkEn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .out_pred_taken(out_pred_taken), .out_pred_target(out_pred_target),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_in(logic [63:0] pc);
        in_pc          = pc;
        in_instr       = $urandom;
        in_pred_taken  = 1'($urandom_range(0, 1));
        in_pred_target = {32'h0, $urandom};
    endtask

    // Checks outputs against the model, then advances model and clock.
    task automatic cycle();
        ent_t h;
        ent_t e;
        bit   exp_ir;
        bit   byp;
        bit   exp_ov;
        bit   do_pop;
        bit   do_push;
        #1;
        e.pc = in_pc; e.instr = in_instr;
        e.tk = in_pred_taken; e.tgt = in_pred_target;
        exp_ir = clkEn && rst && q.size() < 8;
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = clkEn && rst && !flush && in_valid && q.size() == 0;
`endif
        exp_ov = clkEn && rst && (q.size() > 0 || byp);
        check("count", 64'(count), 64'(q.size()));
        check("in_ready", 64'(in_ready), 64'(exp_ir));
        check("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) begin
            h = byp ? e : q[0];
            check("out_pc", out_pc, h.pc);
            check("out_instr", 64'(out_instr), 64'(h.instr));
            check("out_taken", 64'(out_pred_taken), 64'(h.tk));
            check("out_target", out_pred_target, h.tgt);
        end
        do_pop  = exp_ov && out_ready && q.size() > 0 && !flush;
        do_push = in_valid && exp_ir && !flush && !(byp && out_ready);
        @(posedge clk);
        if (clkEn && rst) begin
            if (flush) q.delete();
            else begin
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; clkEn = 1'b1; flush = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        set_in(64'h0);
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_ov", 64'(out_valid), 64'd0);
        check("rst_ir", 64'(in_ready), 64'd0);
        check("rst_pc", out_pc, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ir_after_rst", 64'(in_ready), 64'd1);

        // Three pushes, no pop
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; set_in(64'h1000 + 64'(4 * i));
            cycle();
        end
        in_valid = 1'b0;
        #1;
        check("cnt3", 64'(count), 64'd3);
        check("head3", out_pc, 64'h1000);
        check("ov3", 64'(out_valid), 64'd1);
        cycle();

        // Fill to 8, reject 9th, then push+pop gives pop only
        for (int i = 3; i < 8; i++) begin
            in_valid = 1'b1; set_in(64'h1000 + 64'(4 * i));
            cycle();
        end
        set_in(64'h1020);
        #1;
        check("full_ir", 64'(in_ready), 64'd0);
        check("full_cnt", 64'(count), 64'd8);
        cycle();
        out_ready = 1'b1; set_in(64'h1024);
        cycle();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("cnt7", 64'(count), 64'd7);
        check("head7", out_pc, 64'h1004);

        // Drain to 4, then 20 cycles of steady push+pop across the wrap
        out_ready = 1'b1;
        repeat (3) cycle();
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_in(64'h3000 + 64'(4 * i));
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("steady_cnt", 64'(count), 64'd4);
        cycle();

        // count=5 then flush with a push offered
        in_valid = 1'b1; set_in(64'h4000);
        cycle();
        flush = 1'b1; set_in(64'h4004);
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_cnt", 64'(count), 64'd0);
        check("flush_ov", 64'(out_valid), 64'd0);
        cycle();

        // count=2, clock enable low for 3 cycles
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_in(64'h5000 + 64'(4 * i));
            cycle();
        end
        clkEn = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            set_in(64'h5100);
            cycle();
        end
        clkEn = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
        #1;
        check("ce_cnt", 64'(count), 64'd2);
        cycle();

        // Async reset in mid-stream
        rst = 1'b0;
        #1;
        check("mid_rst_cnt", 64'(count), 64'd0);
        check("mid_rst_ov", 64'(out_valid), 64'd0);
        check("mid_rst_pc", out_pc, 64'd0);
        q.delete();
        cycle();
        rst = 1'b1;

`ifdef FETCH_QUEUE_BYPASS_EN
        in_valid = 1'b1; out_ready = 1'b1;
        in_pc = 64'h2000; in_pred_taken = 1'b1;
        #1;
        check("byp_ov", 64'(out_valid), 64'd1);
        check("byp_pc", out_pc, 64'h2000);
        check("byp_tk", 64'(out_pred_taken), 64'd1);
        cycle();
        in_valid = 1'b0;
        #1;
        check("byp_cnt", 64'(count), 64'd0);
        cycle();
`endif

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            clkEn     = ($urandom_range(0, 9) != 0);
            set_in({$urandom, $urandom});
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
